regfile_writeback_unit: RTL
===========================

Name: regfile_writeback_unit

Overview:
Write-side master of the 32x32 register file. Drives its write port (AddrD/DataD/RegWEn) and merges two result sources: ALU results and in-order data-memory load responses. Performs load byte/halfword extraction and sign/zero extension. Keeps a per-register busy scoreboard so the decode stage can stall on load-use hazards.

Parameters:
LQ_DEPTH, 4, pending-load queue entries (power of 2, >=2)
XLEN, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ld_issue_valid  in  1  load issued to memory this cycle
ld_issue_ready  out  1  queue not full; issue is accepted only when valid&ready
ld_issue_rd  in  5  load destination register
ld_issue_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
ld_issue_off  in  2  byte address bits [1:0]
mem_rsp_valid  in  1  load data returned (in issue order)
mem_rsp_ready  out  1  response accepted
mem_rsp_data  in  XLEN  raw aligned memory word
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
busy  out  32  bit r=1: register r has an outstanding load
RegWEn  out  1  register-file write enable
AddrD  out  5  register-file write address
DataD  out  XLEN  register-file write data
rsp_err  out  1  sticky: response with empty queue, or illegal funct3

Behaviour:
- Reset (async, rst_n=0): RegWEn=0, AddrD=0, DataD=0, busy=0, rsp_err=0, queue empty (ld_issue_ready=1).
- Load queue: FIFO of {rd, funct3, off}. Push on ld_issue_valid&ld_issue_ready. Pop on mem_rsp_valid&mem_rsp_ready. ld_issue_ready = !full. Simultaneous push and pop while full is not allowed (ready=0). Pointers wrap modulo LQ_DEPTH.
- mem_rsp_ready=1 always. A response arriving with the queue empty is dropped: no write, rsp_err set.
- Arbitration, one write per cycle: a valid response with a non-empty queue wins. alu_ready = !(mem_rsp_valid & queue non-empty); combinational, no dependence on alu_valid.
- Extraction: shifted = mem_rsp_data >> (8*off).
  - LB: sign-extend shifted[7:0]. LBU: zero-extend shifted[7:0].
  - LH/LHU use off[1] only (half = mem_rsp_data >> 16*off[1]); sign- or zero-extend [15:0] respectively.
  - LW: full word, off ignored.
  - Other funct3: treated as LW, rsp_err set.
- Write port is registered, 1-cycle latency. On the edge after an accepted response or ALU transfer: RegWEn=1, AddrD=rd, DataD=result. Otherwise RegWEn=0; AddrD/DataD hold their last values.
- rd=0: the transfer is still accepted and the queue still pops, but RegWEn stays 0 and busy[0] is never set.
- Scoreboard:
  - busy[rd] is set on an accepted issue with rd!=0.
  - busy[rd] is cleared on response pop, but only if no other queue entry (excluding the popped one) has the same rd and no same-cycle issue targets rd.
  - If issue and pop hit the same rd in the same cycle, set wins.
  - busy is registered and updates on the same edge as the queue.
- ALU writes never touch busy. Decode is required to stall ALU ops whose rd or rs is busy; this unit does not check for that.
- rsp_err clears only on reset.

Test Plan:
1. Reset then ALU write: alu_valid=1, rd=5, data=0x12345678 -> alu_ready=1; next cycle RegWEn=1, AddrD=5, DataD=0x12345678; the cycle after, RegWEn=0.
2. LB at off=2, rd=7: issue, then rsp data=0x00F30000 -> busy[7]=1 from the cycle after issue until the write edge; write DataD=0xFFFFFFF3, AddrD=7, busy[7]=0. Repeat with LBU -> 0x000000F3. LH off=2 with data 0x80010000 -> 0xFFFF8001.
3. Contention: mem_rsp_valid and alu_valid in the same cycle (queue holds rd=9, ALU rd=3) -> alu_ready=0; rd 9 is written first; with ALU held valid, rd 3 is written on the next cycle.
4. Queue full: 4 issues with no responses -> ld_issue_ready=0 and a 5th issue is not accepted. One response -> ready returns to 1; pointers wrap correctly over 10 subsequent issue/response pairs with data matching in order.
5. Same-rd loads: two loads to rd=4 queued -> after the first response busy[4] stays 1; after the second it clears. Issue to rd=4 in the same cycle as a pop of rd=4 -> busy[4] stays 1.
6. Error/edge cases: a response with an empty queue -> no write, rsp_err=1. A load with rd=0 -> busy[0]=0 and no RegWEn. Assert rst_n mid-flight with 2 loads pending -> busy=0, queue empty, RegWEn=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_writeback_unit.sv
// Register-file write-port master: merges ALU results with in-order load responses,
// extracts/extends load data and keeps a per-register load-busy scoreboard.
module regfile_writeback_unit #(
    parameter int LQ_DEPTH = 4,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_issue_valid,
    output logic            ld_issue_ready,
    input  logic [4:0]      ld_issue_rd,
    input  logic [2:0]      ld_issue_funct3,
    input  logic [1:0]      ld_issue_off,
    input  logic            mem_rsp_valid,
    output logic            mem_rsp_ready,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic [31:0]     busy,
    output logic            RegWEn,
    output logic [4:0]      AddrD,
    output logic [XLEN-1:0] DataD,
    output logic            rsp_err
);

    localparam int PTR_W = $clog2(LQ_DEPTH);

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } ld_funct3_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } lq_entry_t;

    lq_entry_t           lq_mem [LQ_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [31:0]         busy_q, busy_d;
    logic                reg_wen_q, reg_wen_d;
    logic [4:0]          wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;
    logic                rsp_err_q, rsp_err_d;

    lq_entry_t           head;
    logic                lq_empty, lq_full, push, pop, alu_fire;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [XLEN-1:0]     ld_result;
    logic                ld_illegal;
    logic                dup_rd;
    logic [PTR_W-1:0]    scan_idx;

    assign head           = lq_mem[rd_ptr_q];
    assign lq_empty       = (count_q == '0);
    assign lq_full        = (count_q == (PTR_W+1)'(LQ_DEPTH));
    assign ld_issue_ready = !lq_full;
    assign mem_rsp_ready  = 1'b1;
    assign push           = ld_issue_valid && ld_issue_ready;
    assign pop            = mem_rsp_valid && !lq_empty;
    assign alu_ready      = !pop;
    assign alu_fire       = alu_valid && alu_ready;

    assign ld_byte = 8'(mem_rsp_data >> {head.off, 3'b000});
    assign ld_half = 16'(mem_rsp_data >> {head.off[1], 4'b0000});

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ld_result  = mem_rsp_data;
        ld_illegal = 1'b0;
        case (head.funct3)
            F3_LB:   ld_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_result = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LH:   ld_result = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LHU:  ld_result = {{(XLEN-16){1'b0}}, ld_half};
            F3_LW:   ld_result = mem_rsp_data;
            default: ld_illegal = 1'b1;
        endcase
    end

    // Another live entry behind the head still targeting head.rd keeps the register busy.
    always_comb begin
        dup_rd   = 1'b0;
        scan_idx = rd_ptr_q;
        for (int i = 1; i < LQ_DEPTH; i++) begin
            scan_idx = rd_ptr_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (lq_mem[scan_idx].rd == head.rd))
                dup_rd = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Clear first, then set, so a same-cycle issue to the popped rd keeps it busy.
        busy_d = busy_q;
        if (pop && (head.rd != 5'd0) && !dup_rd)
            busy_d[head.rd] = 1'b0;
        if (push && (ld_issue_rd != 5'd0))
            busy_d[ld_issue_rd] = 1'b1;

        reg_wen_d = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (pop) begin
            reg_wen_d = (head.rd != 5'd0);
            wb_addr_d = head.rd;
            wb_data_d = ld_result;
        end else if (alu_fire) begin
            reg_wen_d = (alu_rd != 5'd0);
            wb_addr_d = alu_rd;
            wb_data_d = alu_data;
        end

        rsp_err_d = rsp_err_q || (mem_rsp_valid && lq_empty) || (pop && ld_illegal);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            reg_wen_q <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            reg_wen_q <= reg_wen_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // NOTE: queue payload is not reset; occupancy (count/pointers) decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            lq_mem[wr_ptr_q] <= '{rd: ld_issue_rd, funct3: ld_issue_funct3, off: ld_issue_off};
    end

    assign busy    = busy_q;
    assign RegWEn  = reg_wen_q;
    assign AddrD   = wb_addr_q;
    assign DataD   = wb_data_q;
    assign rsp_err = rsp_err_q;

endmodule
